// File: rtl/snake_pkg.sv
// Shared constants and encodings for the snake game datapath.
// Used by the body controller and the direction FSM.
package snake_pkg;

  localparam int X_CELLS  = 160;
  localparam int Y_CELLS  = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int MAX_LEN  = 32;
  localparam int LEN_W    = 6;
  localparam int INIT_LEN = 4;
  localparam int INIT_X   = 20;
  localparam int INIT_Y   = 15;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  // Opposite directions differ only in the MSB of the encoding.
  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_next_cell.sv
// Combinational next-head computation with grid wrap-around and a guard
// that refuses a 180-degree turn by keeping the last applied direction.
module snake_next_cell
  import snake_pkg::*;
(
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  input  dir_t           dir_in,
  input  dir_t           last_dir,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y,
  output dir_t           dir_applied
);

  // Pick the effective direction, then step one cell with wrap at each edge.
  always_comb begin
    dir_applied = dir_in;
    next_x      = head_x;
    next_y      = head_y;
    if (dir_in == opposite_dir(last_dir)) begin
      dir_applied = last_dir;
    end else begin
      dir_applied = dir_in;
    end
    // Edges are compared before stepping so no result leaves the grid.
    case (dir_applied)
      DIR_RIGHT: next_x = (head_x == X_W'(X_CELLS - 1)) ? X_W'(0) : head_x + X_W'(1);
      DIR_DOWN:  next_y = (head_y == Y_W'(Y_CELLS - 1)) ? Y_W'(0) : head_y + Y_W'(1);
      DIR_LEFT:  next_x = (head_x == X_W'(0)) ? X_W'(X_CELLS - 1) : head_x - X_W'(1);
      DIR_UP:    next_y = (head_y == Y_W'(0)) ? Y_W'(Y_CELLS - 1) : head_y - Y_W'(1);
      default: begin
        next_x = head_x;
        next_y = head_y;
      end
    endcase
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body: segment shift register, growth, self-collision detection and
// the per-cycle occupancy query for the VGA colour path.
module snake_body_ctrl
  import snake_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       DIR_IN,
  input  logic             MOVE_TICK,
  input  logic [X_W-1:0]   TARGET_X,
  input  logic [Y_W-1:0]   TARGET_Y,
  input  logic [X_W-1:0]   PIX_X,
  input  logic [Y_W-1:0]   PIX_Y,
  output logic [X_W-1:0]   HEAD_X,
  output logic [Y_W-1:0]   HEAD_Y,
  output logic             SNAKE_PIXEL,
  output logic             TARGET_REACHED,
  output logic             SELF_HIT,
  output logic [LEN_W-1:0] LENGTH,
  output logic             DEAD
);

  logic [X_W-1:0]   seg_x_r [MAX_LEN];
  logic [Y_W-1:0]   seg_y_r [MAX_LEN];
  logic [LEN_W-1:0] len_r;
  state_t           state_r;
  dir_t             last_dir_r;
  logic             pix_r;
  logic             reach_r;
  logic             hit_r;
  logic             dead_r;

  logic [X_W-1:0]   next_x_s;
  logic [Y_W-1:0]   next_y_s;
  dir_t             dir_applied_s;
  logic             grow_s;
  logic             hit_s;
  logic             pix_s;

  snake_next_cell u_next_cell (
    .head_x      (seg_x_r[0]),
    .head_y      (seg_y_r[0]),
    .dir_in      (dir_t'(DIR_IN)),
    .last_dir    (last_dir_r),
    .next_x      (next_x_s),
    .next_y      (next_y_s),
    .dir_applied (dir_applied_s)
  );

  assign grow_s = (next_x_s == TARGET_X) && (next_y_s == TARGET_Y);

  // Collision bank: the tail vacates on a plain move but stays when growing.
  always_comb begin
    hit_s = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if (((LEN_W'(k) < len_r - LEN_W'(1)) || (grow_s && (LEN_W'(k) < len_r))) &&
          (seg_x_r[k] == next_x_s) && (seg_y_r[k] == next_y_s)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Occupancy query over the live segments only.
  always_comb begin
    pix_s = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((LEN_W'(k) < len_r) && (seg_x_r[k] == PIX_X) && (seg_y_r[k] == PIX_Y)) begin
        pix_s = 1'b1;
      end else begin
        pix_s = pix_s;
      end
    end
  end

  // Game FSM, segment shift, growth and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_r[k] <= X_W'(INIT_X - k);
        seg_y_r[k] <= Y_W'(INIT_Y);
      end
      len_r      <= LEN_W'(INIT_LEN);
      state_r    <= ST_RUN;
      last_dir_r <= DIR_RIGHT;
      pix_r      <= 1'b0;
      reach_r    <= 1'b0;
      hit_r      <= 1'b0;
      dead_r     <= 1'b0;
    end else begin
      pix_r   <= pix_s;
      reach_r <= 1'b0;
      hit_r   <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (MOVE_TICK) begin
            for (int k = 1; k < MAX_LEN; k++) begin
              seg_x_r[k] <= seg_x_r[k-1];
              seg_y_r[k] <= seg_y_r[k-1];
            end
            seg_x_r[0] <= next_x_s;
            seg_y_r[0] <= next_y_s;
            last_dir_r <= dir_applied_s;
            if (grow_s) begin
              reach_r <= 1'b1;
              if (len_r < LEN_W'(MAX_LEN)) begin
                len_r <= len_r + LEN_W'(1);
              end
            end
            if (hit_s) begin
              hit_r   <= 1'b1;
              dead_r  <= 1'b1;
              state_r <= ST_DEAD;
            end
          end
        end
        ST_DEAD: begin
          dead_r <= 1'b1;
        end
        default: begin
          dead_r  <= 1'b1;
          state_r <= ST_DEAD;
        end
      endcase
    end
  end

  assign HEAD_X         = seg_x_r[0];
  assign HEAD_Y         = seg_y_r[0];
  assign SNAKE_PIXEL    = pix_r;
  assign TARGET_REACHED = reach_r;
  assign SELF_HIT       = hit_r;
  assign LENGTH         = len_r;
  assign DEAD           = dead_r;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Scoreboard bench for snake_body_ctrl: stimulus queues hand-computed
// expectations tagged with a cycle; a negedge monitor pops and compares.
module tb_snake_body_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] DIR_IN = 2'b00;
  logic       MOVE_TICK = 1'b0;
  logic [7:0] TARGET_X = 8'd100;
  logic [6:0] TARGET_Y = 7'd100;
  logic [7:0] PIX_X = 8'd0;
  logic [6:0] PIX_Y = 7'd0;
  logic [7:0] HEAD_X;
  logic [6:0] HEAD_Y;
  logic       SNAKE_PIXEL, TARGET_REACHED, SELF_HIT, DEAD;
  logic [5:0] LENGTH;

  snake_body_ctrl dut (
    .CLK(CLK), .RESET(RESET), .DIR_IN(DIR_IN), .MOVE_TICK(MOVE_TICK),
    .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .SNAKE_PIXEL(SNAKE_PIXEL),
    .TARGET_REACHED(TARGET_REACHED), .SELF_HIT(SELF_HIT), .LENGTH(LENGTH), .DEAD(DEAD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [5:0] len;
    logic       dead;
    logic       tr;
    logic       sh;
    logic       chk_pix;
    logic       pix;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         cyc_cnt = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] tgt_x = 8'd100;
  logic [6:0] tgt_y = 7'd100;
  logic [7:0] qx = 8'd0;
  logic [6:0] qy = 7'd0;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic cmp(input string name, input string fld, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0d expected=%0d (cycle %0d)", name, fld, act, exp_v, cyc_cnt);
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge CLK) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc_cnt) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s.stale actual=%0d expected=%0d", mon_e.name, cyc_cnt, mon_e.cyc);
      end else begin
        cmp(mon_e.name, "HEAD_X", HEAD_X, mon_e.hx);
        cmp(mon_e.name, "HEAD_Y", HEAD_Y, mon_e.hy);
        cmp(mon_e.name, "LENGTH", LENGTH, mon_e.len);
        cmp(mon_e.name, "DEAD", DEAD, mon_e.dead);
        cmp(mon_e.name, "TARGET_REACHED", TARGET_REACHED, mon_e.tr);
        cmp(mon_e.name, "SELF_HIT", SELF_HIT, mon_e.sh);
        if (mon_e.chk_pix) cmp(mon_e.name, "SNAKE_PIXEL", SNAKE_PIXEL, mon_e.pix);
      end
    end
  end

  // One cycle of stimulus, applied just after a rising edge.
  task automatic drive(input logic rst, input logic mt, input logic [1:0] dir);
    @(posedge CLK);
    #1;
    RESET = rst; MOVE_TICK = mt; DIR_IN = dir;
    TARGET_X = tgt_x; TARGET_Y = tgt_y; PIX_X = qx; PIX_Y = qy;
  endtask

  // Expected outputs after the edge that samples the last driven inputs.
  task automatic expect_out(input string name, input logic [7:0] hx, input logic [6:0] hy,
                            input logic [5:0] len, input logic dead, input logic tr,
                            input logic sh, input logic chk_pix, input logic pix);
    exp_t e;
    e.cyc = cyc_cnt + 1; e.name = name; e.hx = hx; e.hy = hy; e.len = len;
    e.dead = dead; e.tr = tr; e.sh = sh; e.chk_pix = chk_pix; e.pix = pix;
    sb_q.push_back(e);
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b00); expect_out("reset", 8'd20, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b00); expect_out("tick1", 8'd21, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b00); expect_out("tick2", 8'd22, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b00); expect_out("tick3", 8'd23, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    qx = 8'd20; qy = 7'd15;
    drive(1'b0, 1'b0, 2'b00); expect_out("q_tail", 8'd23, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    qx = 8'd19;
    drive(1'b0, 1'b0, 2'b00); expect_out("q_past_tail", 8'd23, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b10); expect_out("rev_guard", 8'd24, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Walk to the right edge, wrap, then up through the top edge.
    repeat (134) drive(1'b0, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 2'b00); expect_out("at_right", 8'd159, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b00); expect_out("wrap_x", 8'd0, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 2'b00);
    repeat (14) drive(1'b0, 1'b1, 2'b11);
    drive(1'b0, 1'b1, 2'b11); expect_out("at_top", 8'd5, 7'd0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b11); expect_out("wrap_y", 8'd5, 7'd119, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Growth and saturation.
    drive(1'b1, 1'b0, 2'b00); expect_out("reset2", 8'd20, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tgt_x = 8'd21; tgt_y = 7'd15;
    drive(1'b0, 1'b1, 2'b00); expect_out("grow", 8'd21, 7'd15, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tgt_x = 8'd100; tgt_y = 7'd100; qx = 8'd17; qy = 7'd15;
    drive(1'b0, 1'b0, 2'b00); expect_out("grow_tail", 8'd21, 7'd15, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tgt_y = 7'd15;
    for (int i = 0; i < 28; i++) begin
      tgt_x = 8'(22 + i);
      drive(1'b0, 1'b1, 2'b00);
      if (i == 25) expect_out("grow31", 8'd47, 7'd15, 6'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 26) expect_out("grow32", 8'd48, 7'd15, 6'd32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 27) expect_out("grow_sat", 8'd49, 7'd15, 6'd32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tgt_x = 8'd100; tgt_y = 7'd100; qx = 8'd18;
    drive(1'b0, 1'b0, 2'b00); expect_out("full_tail", 8'd49, 7'd15, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    qx = 8'd17;
    drive(1'b0, 1'b0, 2'b00); expect_out("beyond_full", 8'd49, 7'd15, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Chasing the vacating tail is not a collision.
    drive(1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b1, 2'b11); expect_out("tail_vacate", 8'd20, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Same loop but growing onto the tail: both pulses, length still grows.
    drive(1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b10);
    tgt_x = 8'd20; tgt_y = 7'd15;
    drive(1'b0, 1'b1, 2'b11); expect_out("grow_hit", 8'd20, 7'd15, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tgt_x = 8'd100; tgt_y = 7'd100;
    drive(1'b0, 1'b0, 2'b11); expect_out("grow_hit_after", 8'd20, 7'd15, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Grow to 5 then loop into the body.
    drive(1'b1, 1'b0, 2'b00);
    tgt_x = 8'd21; tgt_y = 7'd15;
    drive(1'b0, 1'b1, 2'b00);
    tgt_x = 8'd100; tgt_y = 7'd100;
    drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b1, 2'b11); expect_out("self_hit", 8'd20, 7'd15, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    qx = 8'd21; qy = 7'd16;
    drive(1'b0, 1'b0, 2'b11); expect_out("dead_query", 8'd20, 7'd15, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 2'b00); expect_out("dead_tick", 8'd20, 7'd15, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00); expect_out("reset_dead", 8'd20, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset wins over a tick that would land on the target.
    drive(1'b0, 1'b1, 2'b00);
    tgt_x = 8'd22; tgt_y = 7'd15;
    drive(1'b1, 1'b1, 2'b00); expect_out("rst_tick", 8'd20, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tgt_x = 8'd100; tgt_y = 7'd100;
    drive(1'b0, 1'b0, 2'b00); expect_out("rst_tick_after", 8'd20, 7'd15, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain actual=%0d expected=0 pending", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
Downstream consumer of the direction state machine's 2-bit direction output. On each game-tick pulse it moves the snake head one cell in the current direction, shifts the body segment registers, grows the snake when the head reaches the target, and detects self-collision. It also answers a per-cycle cell-occupancy query from the VGA colour logic.

Parameters:
X_CELLS, 160, grid width in cells (640 px / 4)
Y_CELLS, 120, grid height in cells (480 px / 4)
X_W, 8, X coordinate width
Y_W, 7, Y coordinate width
MAX_LEN, 32, number of segment registers; length saturates here
INIT_LEN, 4, length after reset
INIT_X, 20, head X after reset
INIT_Y, 15, head Y after reset

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
DIR_IN  in  2  direction from the direction FSM: 00 right, 01 down, 10 left, 11 up
MOVE_TICK  in  1  one-cycle pulse; the snake advances one cell per pulse
TARGET_X  in  X_W  target cell X
TARGET_Y  in  Y_W  target cell Y
PIX_X  in  X_W  query cell X from the VGA path
PIX_Y  in  Y_W  query cell Y from the VGA path
HEAD_X  out  X_W  current head X (segment 0)
HEAD_Y  out  Y_W  current head Y
SNAKE_PIXEL  out  1  registered: the query cell is occupied by a live segment
TARGET_REACHED  out  1  one-cycle pulse: the head landed on the target
SELF_HIT  out  1  one-cycle pulse: the head collided with the body
LENGTH  out  6  current live length (INIT_LEN..MAX_LEN)
DEAD  out  1  level: the game is frozen after a collision

Behaviour:
- Reset (synchronous, same edge): state RUN. seg[k] = (INIT_X-k, INIT_Y) for k < MAX_LEN. LENGTH = INIT_LEN. SNAKE_PIXEL, TARGET_REACHED, SELF_HIT and DEAD all 0. Reset takes priority over MOVE_TICK in the same cycle and aborts any move.
- FSM states:
  - RUN -> DEAD when a move detects a self-collision.
  - DEAD -> RUN only through RESET.
  - In DEAD, MOVE_TICK is ignored and segments and length hold.
- Move, when MOVE_TICK=1 in RUN. Everything below is registered on that edge, so outputs update one cycle after the tick.
- New head position, computed from seg[0] and DIR_IN:
  - 00: X+1
  - 01: Y+1
  - 10: X-1
  - 11: Y-1
- Edge wrap-around:
  - X = X_CELLS-1 moving right becomes 0.
  - X = 0 moving left becomes X_CELLS-1.
  - Y behaves the same way with Y_CELLS.
  - No arithmetic result may exceed the range; compare before adding.
- Reversal guard: the last applied direction is registered. A DIR_IN that is the 180° opposite of it is replaced by the last applied direction. This is defensive; the upstream FSM already excludes reversals.
- Shift: seg[k] <= seg[k-1] for 1 <= k < MAX_LEN; seg[0] <= new head. Segments at index >= LENGTH are don't-care and masked everywhere.
- Growth: if the new head equals (TARGET_X, TARGET_Y):
  - TARGET_REACHED pulses.
  - LENGTH increments, saturating at MAX_LEN. At MAX_LEN the pulse still fires.
  - Old tail content is retained by the shift, so the new segment equals the previous tail.
- Collision:
  - Compare the new head against current seg[k] for 0 < k < LENGTH-1. The current tail vacates, so it is excluded.
  - When the same move also grows the snake, the tail is included (k < LENGTH).
  - On a match: SELF_HIT pulses, DEAD=1, state becomes DEAD. The move is still applied on that edge, so HEAD shows the collision cell.
  - If the target and a collision coincide, both pulses fire and LENGTH still increments.
- Pulses last exactly one cycle and are 0 on every non-tick cycle.
- Query: SNAKE_PIXEL is registered one cycle after PIX_X/PIX_Y. It is the OR over k < LENGTH of (seg[k] == PIX). It is evaluated every cycle, including in DEAD. During a move edge it reflects the pre-move segments.
- HEAD_X and HEAD_Y are direct seg[0] outputs.

Decomposition:
- Shared package snake_pkg: the direction encodings DIR_RIGHT=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_UP=2'b11; the grid constants X_CELLS, Y_CELLS, X_W, Y_W; the FSM state encodings RUN and DEAD. The direction FSM is updated to use the same package.
- One natural sub-module, snake_next_cell: combinational next-head computation with wrap-around and the reversal guard.
- The segment array, comparator bank and FSM stay in snake_body_ctrl.

Test Plan:
- Reset, then 3 ticks with DIR_IN=00: HEAD goes (21,15), (22,15), (23,15), each one cycle after its tick. LENGTH=4. Query (20,15) gives SNAKE_PIXEL=1; query (19,15) gives 0.
- Head at (159,15) with DIR_IN=00, then a tick: HEAD=(0,15). Head at (5,0) with DIR_IN=11, then a tick: HEAD=(5,119).
- TARGET=(21,15) and one right tick after reset: TARGET_REACHED high for exactly 1 cycle, LENGTH=5, query (17,15) gives SNAKE_PIXEL=1. Then 28 further target hits: LENGTH saturates at 32.
- Grow to LENGTH=5, then steer down, left, up in a tight loop: SELF_HIT pulses once and DEAD=1. Further ticks leave HEAD unchanged. RESET restores (20,15), LENGTH=4, DEAD=0.
- Snake moving right, DIR_IN forced to 10 on a tick: the head continues right to X+1.
- RESET asserted in the same cycle as MOVE_TICK, with the head at the target: reset values result, and no TARGET_REACHED pulse.
